// File: rtl/ram_arbiter.sv
// Two-master arbiter for the single-port data RAM: core first, bounded wait and optional lock for master 1.
// Latency: zero, grant is combinational. Backpressure: a refused master sees mX_stall_o and must hold its request.
module ram_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_ce_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_stall_o,
  input  logic              m1_ce_i,
  input  logic              m1_we_i,
  input  logic              m1_lock_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_stall_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int LOCK_W = $clog2(MAX_LOCK + 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);
  localparam logic [LOCK_W-1:0] LOCK_SAT = LOCK_W'(MAX_LOCK);

  typedef enum logic {ST_FREE, ST_LOCK} state_t;

  state_t              state, state_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
  logic [LOCK_W-1:0]   lock_cnt, lock_nxt, lock_inc;
  logic                ign_lock, ign_nxt;
  logic                gnt0_raw, gnt1_raw;
  logic                gnt0, gnt1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_FREE;
      wait_cnt <= '0;
      lock_cnt <= '0;
      ign_lock <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      lock_cnt <= lock_nxt;
      ign_lock <= ign_nxt;
    end
  end

  // lock_cnt counts every m1 grant of a locked burst, the one that opens it included,
  // so a burst is at most MAX_LOCK back-to-back m1 accesses.
  always_comb begin
    gnt0_raw  = 1'b0;
    gnt1_raw  = 1'b0;
    state_nxt = state;
    lock_nxt  = lock_cnt;
    ign_nxt   = 1'b0;
    wait_nxt  = wait_cnt;
    lock_inc  = (lock_cnt == LOCK_SAT) ? lock_cnt : lock_cnt + LOCK_W'(1);

    case (state)
      ST_FREE: begin
        lock_nxt = '0;
        if (m1_ce_i && wait_cnt == WAIT_SAT) gnt1_raw = 1'b1;
        else if (m0_ce_i)                    gnt0_raw = 1'b1;
        else if (m1_ce_i)                    gnt1_raw = 1'b1;
        // ign_lock marks the slot right after a lock timeout, reserved for m0
        if (gnt1_raw && m1_lock_i && !ign_lock) begin
          if (lock_inc < LOCK_SAT) begin
            state_nxt = ST_LOCK;
            lock_nxt  = lock_inc;
          end else begin
            ign_nxt = 1'b1;
          end
        end
      end
      ST_LOCK: begin
        gnt1_raw = m1_ce_i;
        if (!m1_ce_i || !m1_lock_i) begin
          state_nxt = ST_FREE;
          lock_nxt  = '0;
        end else if (lock_inc == LOCK_SAT) begin
          state_nxt = ST_FREE;
          lock_nxt  = '0;
          ign_nxt   = 1'b1;
        end else begin
          lock_nxt = lock_inc;
        end
      end
      default: state_nxt = ST_FREE;
    endcase

    if (!m1_ce_i || gnt1_raw)    wait_nxt = '0;
    else if (wait_cnt != WAIT_SAT) wait_nxt = wait_cnt + WAIT_W'(1);
  end

  // Reset gates the grants directly so the RAM is released the moment rst falls.
  assign gnt0 = gnt0_raw & rst;
  assign gnt1 = gnt1_raw & rst;

  always_comb begin
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_data_o = '0;
    if (gnt0) begin
      ram_ce_o   = 1'b1;
      ram_we_o   = m0_we_i;
      ram_addr_o = m0_addr_i;
      ram_data_o = m0_data_i;
    end else if (gnt1) begin
      ram_ce_o   = 1'b1;
      ram_we_o   = m1_we_i;
      ram_addr_o = m1_addr_i;
      ram_data_o = m1_data_i;
    end
  end

  assign m0_data_o  = (gnt0 && !m0_we_i) ? ram_data_i : '0;
  assign m1_data_o  = (gnt1 && !m1_we_i) ? ram_data_i : '0;
  assign m0_stall_o = m0_ce_i & ~gnt0;
  assign m1_stall_o = m1_ce_i & ~gnt1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural RAM: per-cycle expectations are queued when driven.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_ce, m0_we, m1_ce, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdat, m1_addr, m1_wdat;
  logic [31:0] m0_rdat, m1_rdat;
  logic        m0_stall, m1_stall;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdat, ram_rdat;

  logic [31:0] mem [0:63];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic        s0;
    logic        s1;
    logic [31:0] d0;
    logic [31:0] d1;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(8), .MAX_LOCK(16)) dut (
    .clk(clk), .rst(rst),
    .m0_ce_i(m0_ce), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_data_i(m0_wdat),
    .m0_data_o(m0_rdat), .m0_stall_o(m0_stall),
    .m1_ce_i(m1_ce), .m1_we_i(m1_we), .m1_lock_i(m1_lock), .m1_addr_i(m1_addr),
    .m1_data_i(m1_wdat), .m1_data_o(m1_rdat), .m1_stall_o(m1_stall),
    .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_data_o(ram_wdat),
    .ram_data_i(ram_rdat)
  );

  assign ram_rdat = mem[ram_addr[5:0]];
  always @(posedge clk) if (ram_ce && ram_we) mem[ram_addr[5:0]] <= ram_wdat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".ram_ce"},   32'(ram_ce),   32'(e.ce));
      chk({e.tag, ".ram_we"},   32'(ram_we),   32'(e.we));
      chk({e.tag, ".ram_addr"}, ram_addr,      e.addr);
      chk({e.tag, ".ram_data"}, ram_wdat,      e.wdat);
      chk({e.tag, ".m0_stall"}, 32'(m0_stall), 32'(e.s0));
      chk({e.tag, ".m1_stall"}, 32'(m1_stall), 32'(e.s1));
      chk({e.tag, ".m0_data"},  m0_rdat,       e.d0);
      chk({e.tag, ".m1_data"},  m1_rdat,       e.d1);
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic ce, input logic we,
                      input logic [31:0] addr, input logic [31:0] wdat,
                      input logic s0, input logic s1,
                      input logic [31:0] d0, input logic [31:0] d1);
    exp_t e;
    e.tag = tag; e.ce = ce; e.we = we; e.addr = addr; e.wdat = wdat;
    e.s0 = s0; e.s1 = s1; e.d0 = d0; e.d1 = d1;
    sb.push_back(e);
  endtask

  task automatic set_m0(input logic ce, input logic we, input logic [31:0] addr, input logic [31:0] dat);
    m0_ce = ce; m0_we = we; m0_addr = addr; m0_wdat = dat;
  endtask

  task automatic set_m1(input logic ce, input logic we, input logic lock,
                        input logic [31:0] addr, input logic [31:0] dat);
    m1_ce = ce; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wdat = dat;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rst = 1'b0;
    set_m0(1'b1, 1'b1, 32'h10, 32'h1234_5678);
    set_m1(1'b1, 1'b1, 1'b1, 32'h11, 32'h8765_4321);

    // Reset: nothing granted, stalls follow the requests.
    next();
    push("reset", 0, 0, 0, 0, 1, 1, 0, 0);

    next();
    rst = 1'b1;
    set_m0(0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0);
    push("idle0", 0, 0, 0, 0, 0, 0, 0, 0);

    // Single-master write then read-back.
    next();
    set_m0(1, 1, 32'h10, 32'hDEAD_BEEF);
    push("m0_wr", 1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0);
    next();
    set_m0(1, 0, 32'h10, 0);
    push("m0_rd", 1, 0, 32'h10, 0, 0, 0, 32'hDEAD_BEEF, 0);

    // Contention: m1 refused 8 cycles, forced on the 9th, then m0 again.
    next();
    set_m1(1, 1, 0, 32'h20, 32'h1111_1111);
    push("cont_w0", 1, 0, 32'h10, 0, 0, 1, 32'hDEAD_BEEF, 0);
    for (int i = 1; i < 8; i++) begin
      next();
      push($sformatf("cont_w%0d", i), 1, 0, 32'h10, 0, 0, 1, 32'hDEAD_BEEF, 0);
    end
    next();
    push("cont_m1", 1, 1, 32'h20, 32'h1111_1111, 1, 0, 0, 0);
    next();
    push("cont_m0", 1, 0, 32'h10, 0, 0, 1, 32'hDEAD_BEEF, 0);
    next();
    set_m1(0, 0, 0, 0, 0);
    set_m0(1, 0, 32'h20, 0);
    push("cont_rb", 1, 0, 32'h20, 0, 0, 0, 32'h1111_1111, 0);

    // Lock: four locked m1 writes after the forced grant, m0 shut out meanwhile.
    next();
    set_m0(1, 0, 32'h10, 0);
    set_m1(1, 1, 1, 32'h30, 32'hA000_0000);
    push("lk_w0", 1, 0, 32'h10, 0, 0, 1, 32'hDEAD_BEEF, 0);
    for (int i = 1; i < 8; i++) begin
      next();
      push($sformatf("lk_w%0d", i), 1, 0, 32'h10, 0, 0, 1, 32'hDEAD_BEEF, 0);
    end
    for (int i = 0; i < 4; i++) begin
      next();
      set_m1(1, 1, (i != 3), 32'h30 + 32'(i), 32'hA000_0000 + 32'(i));
      push($sformatf("lk_m1_%0d", i), 1, 1, 32'h30 + 32'(i), 32'hA000_0000 + 32'(i), 1, 0, 0, 0);
    end
    next();
    set_m1(0, 0, 0, 0, 0);
    push("lk_rel", 1, 0, 32'h10, 0, 0, 0, 32'hDEAD_BEEF, 0);
    for (int i = 0; i < 4; i++) begin
      next();
      set_m0(1, 0, 32'h30 + 32'(i), 0);
      push($sformatf("lk_rb%0d", i), 1, 0, 32'h30 + 32'(i), 0, 0, 0, 32'hA000_0000 + 32'(i), 0);
    end

    // Lock timeout: 16 m1 grants, one m0 slot, then m1 relocks.
    next();
    set_m0(1, 0, 32'h10, 0);
    set_m1(1, 0, 1, 32'h30, 0);
    push("to_w0", 1, 0, 32'h10, 0, 0, 1, 32'hDEAD_BEEF, 0);
    for (int i = 1; i < 8; i++) begin
      next();
      push($sformatf("to_w%0d", i), 1, 0, 32'h10, 0, 0, 1, 32'hDEAD_BEEF, 0);
    end
    for (int i = 0; i < 16; i++) begin
      next();
      push($sformatf("to_m1_%0d", i), 1, 0, 32'h30, 0, 1, 0, 0, 32'hA000_0000);
    end
    next();
    push("to_m0", 1, 0, 32'h10, 0, 0, 1, 32'hDEAD_BEEF, 0);
    next();
    set_m0(0, 0, 0, 0);
    push("relock", 1, 0, 32'h30, 0, 0, 0, 0, 32'hA000_0000);
    next();
    set_m0(1, 0, 32'h10, 0);
    push("relock_hold", 1, 0, 32'h30, 0, 1, 0, 0, 32'hA000_0000);

    // Async reset in the middle of a locked write.
    next();
    set_m0(1, 0, 32'h3F, 0);
    set_m1(1, 1, 1, 32'h3F, 32'h5555_5555);
    #2;
    rst = 1'b0;
    #1;
    chk("arst.ram_ce_now", 32'(ram_ce), 32'h0);
    chk("arst.ram_we_now", 32'(ram_we), 32'h0);
    push("arst", 0, 0, 0, 0, 1, 1, 0, 0);
    next();
    rst = 1'b1;
    set_m1(1, 0, 1, 32'h30, 0);
    push("arst_rel", 1, 0, 32'h3F, 0, 0, 1, 32'h0, 0);

    next();
    set_m0(0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0);
    push("idle1", 0, 0, 0, 0, 0, 0, 0, 0);

    next();
    next();
    chk("sb_drain", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
